// File: rtl/mips_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mips_dmem_responder
// Brief    : MEM-stage data-memory responder. It handles one load or store at a
//            time, responds after a fixed wait, and stalls the pipeline while busy.
// Revision : 1.0 - initial release
// ============================================================================
module mips_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        mem_stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] stall_count
);

    localparam int c_IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [3:0]          w_next_cnt;
    logic                r_we;
    logic [c_IDX_W-1:0]  r_idx;
    logic [31:0]         r_wdata;
    logic [3:0]          r_be;
    logic                r_oob;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;
    logic [31:0]         r_stall_count;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_req_oob;
    logic                w_enter_resp;
    logic                w_src_we;
    logic                w_src_oob;
    logic [c_IDX_W-1:0]  w_src_idx;
    logic                w_unused_addr_lsb;

    // The full word address is compared, so high address bits never alias into the array.
    assign w_req_oob         = (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_accept          = (r_state == S_IDLE) && req_valid;
    assign w_enter_resp      = (w_next_state == S_RESP) && (r_state != S_RESP);
    assign w_unused_addr_lsb = ^req_addr[1:0];

    // With zero latency the request enters RESP directly from IDLE before it has been latched.
    assign w_src_we  = w_accept ? req_we                    : r_we;
    assign w_src_oob = w_accept ? w_req_oob                 : r_oob;
    assign w_src_idx = w_accept ? req_addr[c_IDX_W+1:2]     : r_idx;

    assign mem_stall   = w_accept || (r_state == S_WAIT);
    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_rdata   = r_rsp_rdata;
    assign rsp_err     = r_rsp_err;
    assign stall_count = r_stall_count;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next_cnt   = 4'(LATENCY);
                    w_next_state = (LATENCY > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                // Ignores req_valid, so a dropped request still drains to RESP.
                if (r_cnt <= 4'd1) begin
                    w_next_cnt   = 4'd0;
                    w_next_state = S_RESP;
                end else begin
                    w_next_cnt = r_cnt - 4'd1;
                end
            end
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= 4'd0;
            r_we          <= 1'b0;
            r_idx         <= '0;
            r_wdata       <= 32'd0;
            r_be          <= 4'd0;
            r_oob         <= 1'b0;
            r_rsp_rdata   <= 32'd0;
            r_rsp_err     <= 1'b0;
            r_stall_count <= 32'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
            if (w_accept) begin
                r_we    <= req_we;
                r_idx   <= req_addr[c_IDX_W+1:2];
                r_wdata <= req_wdata;
                r_be    <= req_be;
                r_oob   <= w_req_oob;
            end
            if (w_enter_resp) begin
                r_rsp_err   <= w_src_oob;
                r_rsp_rdata <= (w_src_we || w_src_oob) ? 32'd0 : r_mem[w_src_idx];
            end
            if (mem_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    // The store commits on the edge that ends RESP; a reset during RESP clears the state first.
    always_ff @(posedge clk) begin
        if ((r_state == S_RESP) && r_we && !r_oob) begin
            for (int i = 0; i < 4; i++) begin
                if (r_be[i]) begin
                    r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
